interrupt_factor_controller: RTL and testbench
==============================================

// Module: interrupt_factor_controller
// PURPOSE
// Requester side of the CPU interrupt handshake. Collects peripheral events into sticky 4-bit
// factor flags, gates them with mask registers and drives interrupt_req[14:0] to the microcode
// sequencer. Tracks performing_interrupt/interrupt_address acknowledges, exposes factor/mask
// registers to the CPU (factors clear on read), and edge-detects the K0x/K1x input pins.
// PARAMETERS
// K_SYNC_STAGES  2  synchroniser depth on k0_pins/k1_pins (minimum 2)
// PORTS
// clk                   in   1   system clock
// reset                 in   1   synchronous, active-high
// clk_en                in   1   CPU clock enable; all state advances only when high
// timer_events          in   4   clock-timer pulses (1 clk_en each), group 0, vector 2
// stopwatch_events      in   4   stopwatch pulses, group 1, vector 4
// k0_pins               in   4   K00-K03 levels, async, group 2, vector 6
// k1_pins               in   4   K10-K13 levels, async, group 3, vector 8
// serial_events         in   4   serial pulses, group 4, vector 10
// prog_timer_events     in   4   programmable-timer pulses, group 5, vector 12
// reg_addr              in   4   local register index
// reg_read              in   1   read strobe, sampled on clk_en
// reg_write             in   1   write strobe, sampled on clk_en
// reg_wdata             in   4   write data
// reg_rdata             out  4   read data, registered
// performing_interrupt  in   1   from sequencer; high while the interrupt sequence runs
// interrupt_address     in   4   vector being serviced, valid while performing_interrupt
// interrupt_req         out  15  per-vector request; bit n = vector n
// in_service_vector     out  4   last acknowledged vector
// ack_pulse             out  1   1-clk pulse on acknowledge
// BEHAVIOUR
// - Register map: 0-5 factor g (RO, clear-on-read); 8-13 mask g (RW); 14 K0 edge select
//   (1=falling, 0=rising); 15 K1 edge select; others read 0, writes ignored.
// - Reset: all factors, masks and edge selects 0; reg_rdata=0; interrupt_req=0;
//   in_service_vector=0; ack_pulse=0; synchroniser and previous-pin regs loaded with 0.
// - Pulse groups: on clk_en, factor_g <= factor_g | events. Events arriving while clk_en=0 are
//   lost (peripherals only pulse on clk_en).
// - K groups: pins pass K_SYNC_STAGES flops clocked on clk (not gated); edge detect compares
//   synced vs previous sample taken on clk_en; selected edge on bit i sets factor bit i.
//   Edge-select change takes effect next clk_en and never creates a spurious edge itself.
// - interrupt_req: combinational from registered state; bit(2g+2) = |(factor_g & mask_g);
//   bits 0,1,3,5,7,9,11,13,14 tied 0. Priority resolution is the sequencer's job.
// - Read: on clk_en & reg_read, reg_rdata <= selected reg (1-cycle latency, holds until next
//   read). Factor read clears that factor on same edge; event set on same edge wins, so bit
//   stays 1 and rdata shows pre-set value; the next read returns it.
// - Write: on clk_en & reg_write, masks/edge selects update; writes to factor addrs ignored.
//   Simultaneous reg_read & reg_write: read sees old value, write applies.
// - Clearing a mask does not clear factors; re-enabling mask re-asserts request immediately.
// - Acknowledge: rising edge of performing_interrupt (previous sample kept on clk) latches
//   interrupt_address into in_service_vector, ack_pulse=1 for one clk. Factors NOT cleared by
//   acknowledge; software clears by reading. Held performing_interrupt = single ack only.
// - Reset mid-operation: all state returns to reset values on the next clk regardless of
//   clk_en; pending factors are discarded.
// TESTING
// - mask8=0x1, timer_events=0x1 pulse -> interrupt_req[2]=1 next cycle; read addr 0 ->
//   rdata=0x1, interrupt_req[2]=0 after.
// - mask=0, prog_timer_events=0x4 -> interrupt_req=0; write mask13=0xF -> interrupt_req[12]=1.
// - edge select 14=1, k0_pins[1] 1->0 -> factor2=0x2 after K_SYNC_STAGES+1 clk_en; 0->1
//   -> no set.
// - serial_events=0x1 on same clk_en as read of addr 4 (factor 0x0) -> rdata=0x0, next read
//   0x1.
// - performing_interrupt high 12 cycles with interrupt_address=6 -> one ack_pulse,
//   in_service_vector=6, factor2 unchanged.
// - factors/masks set, reset asserted with clk_en=0 -> all outputs 0 next clk.

Source files
------------

// File: rtl/interrupt_factor_controller.sv
// -----------------------------------------------------------------------------
// interrupt_factor_controller
//
// Requester side of the CPU interrupt handshake. Peripheral events are folded
// into sticky 4-bit factor flags (six groups), gated by per-group masks, and
// presented to the microcode sequencer as interrupt_req (group g -> vector
// 2g+2). K0x/K1x pins are synchronised and edge-detected into groups 2 and 3.
// Factor registers clear when the CPU reads them. Acknowledges from the
// sequencer are tracked as a rising edge of performing_interrupt.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   clk_en                CPU clock enable; architectural state advances only
//                         when high (pin synchroniser and ack detector run on clk)
//   timer_events          group 0 event pulses (vector 2)
//   stopwatch_events      group 1 event pulses (vector 4)
//   k0_pins / k1_pins     async pin levels, groups 2/3 (vectors 6/8)
//   serial_events         group 4 event pulses (vector 10)
//   prog_timer_events     group 5 event pulses (vector 12)
//   reg_addr/read/write/wdata/rdata   local register port, rdata registered
//   performing_interrupt  sequencer busy flag; rising edge = acknowledge
//   interrupt_address     vector being serviced
//   interrupt_req         per-vector request lines
//   in_service_vector     last acknowledged vector
//   ack_pulse             one-clk pulse per acknowledge
// -----------------------------------------------------------------------------
module interrupt_factor_controller #(
   parameter int K_SYNC_STAGES = 2   // minimum 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic [3:0]  timer_events,
   input  logic [3:0]  stopwatch_events,
   input  logic [3:0]  k0_pins,
   input  logic [3:0]  k1_pins,
   input  logic [3:0]  serial_events,
   input  logic [3:0]  prog_timer_events,
   input  logic [3:0]  reg_addr,
   input  logic        reg_read,
   input  logic        reg_write,
   input  logic [3:0]  reg_wdata,
   output logic [3:0]  reg_rdata,
   input  logic        performing_interrupt,
   input  logic [3:0]  interrupt_address,
   output logic [14:0] interrupt_req,
   output logic [3:0]  in_service_vector,
   output logic        ack_pulse
);

   localparam int NUM_GROUPS = 6;

   logic [3:0] factor_r [NUM_GROUPS];
   logic [3:0] mask_r   [NUM_GROUPS];
   logic       k0_sel_r;            // 1 = falling edge, 0 = rising edge
   logic       k1_sel_r;
   logic [3:0] k0_sync_r [K_SYNC_STAGES];
   logic [3:0] k1_sync_r [K_SYNC_STAGES];
   logic [3:0] k0_prev_r;
   logic [3:0] k1_prev_r;
   logic       perf_prev_r;

   logic [3:0] k0_synced_s;
   logic [3:0] k1_synced_s;
   logic [3:0] k0_edge_s;
   logic [3:0] k1_edge_s;
   logic [3:0] set_s      [NUM_GROUPS];
   logic [3:0] reg_view_s [16];
   logic [3:0] rd_mux_s;

   assign k0_synced_s = k0_sync_r[K_SYNC_STAGES-1];
   assign k1_synced_s = k1_sync_r[K_SYNC_STAGES-1];

   // Pin synchronisers, free-running on clk so the pin history is not gated.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < K_SYNC_STAGES; s++) begin
            k0_sync_r[s] <= 4'h0;
            k1_sync_r[s] <= 4'h0;
         end
      end else begin
         k0_sync_r[0] <= k0_pins;
         k1_sync_r[0] <= k1_pins;
         for (int s = 1; s < K_SYNC_STAGES; s++) begin
            k0_sync_r[s] <= k0_sync_r[s-1];
            k1_sync_r[s] <= k1_sync_r[s-1];
         end
      end
   end

   // Edge detection: the select only picks which polarity of an existing
   // synced/previous difference counts, so changing it cannot invent an edge.
   always_comb begin
      k0_edge_s = 4'h0;
      k1_edge_s = 4'h0;
      if (k0_sel_r) begin
         k0_edge_s = ~k0_synced_s & k0_prev_r;
      end else begin
         k0_edge_s = k0_synced_s & ~k0_prev_r;
      end
      if (k1_sel_r) begin
         k1_edge_s = ~k1_synced_s & k1_prev_r;
      end else begin
         k1_edge_s = k1_synced_s & ~k1_prev_r;
      end
   end

   // Per-group set vectors.
   always_comb begin
      set_s[0] = timer_events;
      set_s[1] = stopwatch_events;
      set_s[2] = k0_edge_s;
      set_s[3] = k1_edge_s;
      set_s[4] = serial_events;
      set_s[5] = prog_timer_events;
   end

   // Flat view of the register map for the read mux; holes read as zero.
   always_comb begin
      for (int a = 0; a < 16; a++) begin
         reg_view_s[a] = 4'h0;
      end
      for (int g = 0; g < NUM_GROUPS; g++) begin
         reg_view_s[g]     = factor_r[g];
         reg_view_s[g + 8] = mask_r[g];
      end
      reg_view_s[14] = {3'b000, k0_sel_r};
      reg_view_s[15] = {3'b000, k1_sel_r};
      rd_mux_s = reg_view_s[reg_addr];
   end

   // Architectural state: factors, masks, edge selects, pin history, rdata.
   // A factor read clears the flags, but an event on the same edge is OR-ed
   // in afterwards so it survives for the next read.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            factor_r[g] <= 4'h0;
            mask_r[g]   <= 4'h0;
         end
         k0_sel_r  <= 1'b0;
         k1_sel_r  <= 1'b0;
         k0_prev_r <= 4'h0;
         k1_prev_r <= 4'h0;
         reg_rdata <= 4'h0;
      end else if (clk_en) begin
         k0_prev_r <= k0_synced_s;
         k1_prev_r <= k1_synced_s;
         if (reg_read) begin
            reg_rdata <= rd_mux_s;
         end
         for (int g = 0; g < NUM_GROUPS; g++) begin
            if (reg_read && (reg_addr == 4'(g))) begin
               factor_r[g] <= set_s[g];
            end else begin
               factor_r[g] <= factor_r[g] | set_s[g];
            end
            if (reg_write && (reg_addr == 4'(g + 8))) begin
               mask_r[g] <= reg_wdata;
            end
         end
         if (reg_write && (reg_addr == 4'd14)) begin
            k0_sel_r <= reg_wdata[0];
         end
         if (reg_write && (reg_addr == 4'd15)) begin
            k1_sel_r <= reg_wdata[0];
         end
      end
   end

   // Acknowledge tracking on clk: one pulse per rising edge of the busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_prev_r       <= 1'b0;
         ack_pulse         <= 1'b0;
         in_service_vector <= 4'h0;
      end else begin
         perf_prev_r <= performing_interrupt;
         ack_pulse   <= performing_interrupt & ~perf_prev_r;
         if (performing_interrupt && !perf_prev_r) begin
            in_service_vector <= interrupt_address;
         end
      end
   end

   // Request lines: group g drives vector 2g+2, odd and unused vectors stay low.
   always_comb begin
      interrupt_req = 15'h0000;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         interrupt_req[2*g + 2] = |(factor_r[g] & mask_r[g]);
      end
   end

endmodule

// File: tb/tb_interrupt_factor_controller.sv
module tb_interrupt_factor_controller;

   localparam int K = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic [3:0]  timer_events, stopwatch_events, k0_pins, k1_pins;
   logic [3:0]  serial_events, prog_timer_events;
   logic [3:0]  reg_addr, reg_wdata, reg_rdata;
   logic        reg_read, reg_write;
   logic        performing_interrupt;
   logic [3:0]  interrupt_address, in_service_vector;
   logic [14:0] interrupt_req;
   logic        ack_pulse;

   int checks = 0;
   int failures = 0;

   interrupt_factor_controller #(.K_SYNC_STAGES(K)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .timer_events(timer_events), .stopwatch_events(stopwatch_events),
      .k0_pins(k0_pins), .k1_pins(k1_pins),
      .serial_events(serial_events), .prog_timer_events(prog_timer_events),
      .reg_addr(reg_addr), .reg_read(reg_read), .reg_write(reg_write),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .performing_interrupt(performing_interrupt),
      .interrupt_address(interrupt_address),
      .interrupt_req(interrupt_req), .in_service_vector(in_service_vector),
      .ack_pulse(ack_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rd;
      logic        wr;
      logic [3:0]  addr;
      logic [3:0]  wdata;
      logic [3:0]  tmr;
      logic [3:0]  stw;
      logic [3:0]  ser;
      logic [3:0]  prg;
      logic [3:0]  exp_rdata;
      logic [14:0] exp_req;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic en, logic rd, logic wr, logic [3:0] addr,
                               logic [3:0] wdata, logic [3:0] tmr, logic [3:0] stw,
                               logic [3:0] ser, logic [3:0] prg,
                               logic [3:0] exp_rdata, logic [14:0] exp_req);
      vec_t v;
      v.en = en; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.tmr = tmr; v.stw = stw; v.ser = ser; v.prg = prg;
      v.exp_rdata = exp_rdata; v.exp_req = exp_req;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clk_en = 1'b1; reg_read = 1'b0; reg_write = 1'b0;
      reg_addr = 4'h0; reg_wdata = 4'h0;
      timer_events = 4'h0; stopwatch_events = 4'h0;
      serial_events = 4'h0; prog_timer_events = 4'h0;
   endtask

   task automatic reg_rd(input logic [3:0] a);
      reg_read = 1'b1; reg_addr = a;
      tick();
      reg_read = 1'b0;
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [3:0] d);
      reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_write = 1'b0;
   endtask

   int acks;

   initial begin
      idle_inputs();
      reset = 1'b1; k0_pins = 4'h0; k1_pins = 4'h0;
      performing_interrupt = 1'b0; interrupt_address = 4'h0;
      tick(); tick();
      check("reset_rdata", reg_rdata, 0);
      check("reset_req", interrupt_req, 0);
      check("reset_isv", in_service_vector, 0);
      check("reset_ack", ack_pulse, 0);
      reset = 1'b0;

      //   en rd wr addr wd  tmr stw ser prg  rdata req
      add(1, 0, 1, 8,  1,  0,  0,  0,  0,   0, 15'h0000); // mask0=1
      add(1, 0, 0, 0,  0,  1,  0,  0,  0,   0, 15'h0004); // timer pulse
      add(1, 1, 0, 0,  0,  0,  0,  0,  0,   1, 15'h0000); // read clears
      add(1, 1, 0, 8,  0,  0,  0,  0,  0,   1, 15'h0000);
      add(1, 0, 0, 0,  0,  0,  0,  0,  4,   1, 15'h0000); // masked
      add(1, 0, 1, 13, 15, 0,  0,  0,  0,   1, 15'h1000); // unmask
      add(1, 1, 0, 5,  0,  0,  0,  0,  0,   4, 15'h0000);
      add(1, 1, 0, 4,  0,  0,  0,  1,  0,   0, 15'h0000); // set wins over clear
      add(1, 1, 0, 4,  0,  0,  0,  0,  0,   1, 15'h0000);
      add(1, 0, 0, 0,  0,  0,  0,  2,  0,   1, 15'h0000);
      add(1, 0, 1, 12, 1,  0,  0,  0,  0,   1, 15'h0000); // non-matching mask bit
      add(1, 0, 1, 12, 2,  0,  0,  0,  0,   1, 15'h0400);
      add(1, 0, 1, 12, 0,  0,  0,  0,  0,   1, 15'h0000); // mask clear keeps factor
      add(1, 0, 1, 12, 2,  0,  0,  0,  0,   1, 15'h0400); // re-enable
      add(1, 1, 1, 12, 15, 0,  0,  0,  0,   2, 15'h0400); // read old, write applies
      add(1, 1, 0, 12, 0,  0,  0,  0,  0,  15, 15'h0400);
      add(1, 1, 1, 7,  0,  0,  0,  0,  0,   0, 15'h0400); // hole reads 0
      add(1, 0, 1, 0,  15, 0,  0,  0,  0,   0, 15'h0400); // factor write ignored
      add(1, 1, 0, 0,  0,  0,  0,  0,  0,   0, 15'h0400);
      add(1, 1, 0, 4,  0,  0,  0,  0,  0,   2, 15'h0000);
      add(0, 1, 0, 8,  0,  1,  0,  0,  0,   2, 15'h0000); // clk_en low: all ignored
      add(1, 1, 0, 0,  0,  0,  0,  0,  0,   0, 15'h0000);
      add(1, 1, 1, 14, 1,  0,  0,  0,  0,   0, 15'h0000); // K0 falling select
      add(1, 1, 0, 14, 0,  0,  0,  0,  0,   1, 15'h0000);
      add(1, 0, 1, 10, 15, 0,  0,  0,  0,   1, 15'h0000); // mask2; no spurious edge
      add(1, 0, 0, 0,  0,  0,  8,  0,  0,   1, 15'h0000);
      add(1, 0, 1, 9,  8,  0,  0,  0,  0,   1, 15'h0010);
      add(1, 1, 0, 1,  0,  0,  0,  0,  0,   8, 15'h0000);

      foreach (vecs[i]) begin
         clk_en = vecs[i].en; reg_read = vecs[i].rd; reg_write = vecs[i].wr;
         reg_addr = vecs[i].addr; reg_wdata = vecs[i].wdata;
         timer_events = vecs[i].tmr; stopwatch_events = vecs[i].stw;
         serial_events = vecs[i].ser; prog_timer_events = vecs[i].prg;
         tick();
         check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_req", i), interrupt_req, vecs[i].exp_req);
      end
      idle_inputs();

      // K0 falling edge: rising edge on pin 1 must not set anything.
      k0_pins = 4'b0010;
      for (int i = 0; i < K + 2; i++) tick();
      check("k0_rise_ignored", interrupt_req[6], 0);
      k0_pins = 4'b0000;
      for (int i = 0; i < K; i++) tick();
      check("k0_fall_early", interrupt_req[6], 0);
      tick();
      check("k0_fall_set", interrupt_req[6], 1);

      // K1 rising edge (default select) on pin 0.
      reg_wr(4'd11, 4'h1);
      k1_pins = 4'b0001;
      for (int i = 0; i < K + 1; i++) tick();
      check("k1_rise_set", interrupt_req[8], 1);
      reg_rd(4'd3);
      check("k1_factor_read", reg_rdata, 4'h1);
      check("k1_cleared", interrupt_req[8], 0);

      // Acknowledge: long busy window, single pulse, factors untouched.
      acks = 0;
      interrupt_address = 4'd6;
      performing_interrupt = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack_pulse) acks++;
      end
      performing_interrupt = 1'b0;
      tick();
      if (ack_pulse) acks++;
      check("ack_count", acks, 1);
      check("ack_isv", in_service_vector, 4'd6);
      check("ack_factor_kept", interrupt_req[6], 1);
      reg_rd(4'd2);
      check("k0_factor_read", reg_rdata, 4'h2);
      check("k0_cleared", interrupt_req[6], 0);

      // Reset mid-operation with clk_en low.
      timer_events = 4'h3; tick(); timer_events = 4'h0;
      check("pre_reset_req", interrupt_req, 15'h0004);
      reg_rd(4'd10);
      check("pre_reset_rdata", reg_rdata, 4'hF);
      clk_en = 1'b0; reset = 1'b1;
      tick();
      check("midreset_rdata", reg_rdata, 0);
      check("midreset_req", interrupt_req, 0);
      check("midreset_isv", in_service_vector, 0);
      check("midreset_ack", ack_pulse, 0);
      reset = 1'b0; clk_en = 1'b1;
      reg_rd(4'd0);
      check("post_reset_factor0", reg_rdata, 0);
      reg_rd(4'd8);
      check("post_reset_mask0", reg_rdata, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
